// File: rtl/mixer.sv
// Signed fixed-point multiplier with saturation: one-cycle latency, full throughput.
// Product is formed at full double width, floor-scaled by the fraction width, then clamped.
module mixer #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_FRAC_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [PW-1:0] MAX_WIDE = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_WIDE = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_CODE = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_CODE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [PW-1:0]   a_ext;
    logic signed [PW-1:0]   b_ext;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   scaled;
    logic [DATA_WIDTH-1:0]  sat;
    logic                   ov_c;
    logic                   un_c;

    // Explicit sign extension keeps the multiply exact: the true product always fits in PW bits.
    assign a_ext  = {{DATA_WIDTH{in_a[DATA_WIDTH-1]}}, in_a};
    assign b_ext  = {{DATA_WIDTH{in_b[DATA_WIDTH-1]}}, in_b};
    assign prod   = a_ext * b_ext;
    assign scaled = prod >>> DATA_FRAC_WIDTH;

    always_comb begin
        ov_c = 1'b0;
        un_c = 1'b0;
        sat  = scaled[DATA_WIDTH-1:0];
        if (scaled > MAX_WIDE) begin
            ov_c = 1'b1;
            sat  = MAX_CODE;
        end else if (scaled < MIN_WIDE) begin
            un_c = 1'b1;
            sat  = MIN_CODE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out       <= sat;
                overflow  <= ov_c;
                underflow <= un_c;
            end
        end
    end

endmodule

// File: tb/tb_mixer.sv
// Scoreboard bench for mixer: expected results queued at drive time, compared on out_valid.
module tb_mixer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] out;
    logic        out_valid;
    logic        overflow;
    logic        underflow;

    typedef struct packed {
        logic [31:0] o;
        logic        ov;
        logic        un;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          nres  = 0;
    logic [31:0] last_out = '0;

    mixer #(.DATA_WIDTH(32), .DATA_FRAC_WIDTH(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .out       (out),
        .out_valid (out_valid),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Independent arithmetic model using 64-bit integers.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        longint s;
        p = longint'($signed(a)) * longint'($signed(b));
        s = p >>> 23;
        e.ov = 1'b0;
        e.un = 1'b0;
        if (s > 64'sd2147483647) begin
            e.o  = 32'h7FFFFFFF;
            e.ov = 1'b1;
        end else if (s < -64'sd2147483648) begin
            e.o  = 32'h80000000;
            e.un = 1'b1;
        end else begin
            e.o = s[31:0];
        end
        return e;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        q.push_back(model(a, b));
    endtask

    task automatic send_exp(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] o, input logic ov, input logic un);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        e.o  = o;
        e.ov = ov;
        e.un = un;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            exp_t e;
            if (q.size() == 0) begin
                chk("spurious_valid", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("out", {32'd0, out}, {32'd0, e.o});
                chk("overflow", {63'd0, overflow}, {63'd0, e.ov});
                chk("underflow", {63'd0, underflow}, {63'd0, e.un});
                last_out = e.o;
                nres++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          n0;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        #1;
        chk("rst_out", {32'd0, out}, 64'd0);
        chk("rst_flags", {62'd0, overflow, underflow}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-derived expectations, back to back.
        send_exp(32'h00000B24, 32'h00800000, 32'h00000B24, 1'b0, 1'b0);
        send_exp(32'h7FFFFFFF, 32'h00800001, 32'h7FFFFFFF, 1'b1, 1'b0);
        send_exp(32'h80000000, 32'h00800001, 32'h80000000, 1'b0, 1'b1);
        send_exp(32'h7FFFFFFE, 32'h00800000, 32'h7FFFFFFE, 1'b0, 1'b0);
        send_exp(32'h80000001, 32'h00800000, 32'h80000001, 1'b0, 1'b0);
        send_exp(32'hFF800000, 32'h00400000, 32'hFFC00000, 1'b0, 1'b0);
        send_exp(32'hFFFFFFFF, 32'h00400000, 32'hFFFFFFFF, 1'b0, 1'b0);
        send_exp(32'h7FFFFFFF, 32'h00800000, 32'h7FFFFFFF, 1'b0, 1'b0);
        send_exp(32'h80000000, 32'h00800000, 32'h80000000, 1'b0, 1'b0);
        send_exp(32'h80000000, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0);
        send_exp(32'h00400000, 32'hFF800000, 32'hFFC00000, 1'b0, 1'b0);

        // Gap: out_valid drops and the last result holds.
        idle();
        @(negedge clk);
        chk("gap_valid", {63'd0, out_valid}, 64'd0);
        chk("gap_hold", {32'd0, out}, {32'd0, last_out});
        chk("gap_flags", {62'd0, overflow, underflow}, 64'd0);

        // Random pairs, each also sent swapped, with occasional gaps.
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom_range(0, 32'h00FFFFFF);
                1: rb = 32'hFF000000 | $urandom_range(0, 32'h00FFFFFF);
                default: ;
            endcase
            send(ra, rb);
            send(rb, ra);
            if ($urandom_range(0, 5) == 0) idle();
        end

        // Mid-stream reset discards the in-flight result.
        send(32'h01000000, 32'h01000000);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {32'd0, out}, 64'd0);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_flags", {62'd0, overflow, underflow}, 64'd0);
        q.delete();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("post_rst_out", {32'd0, out}, 64'd0);

        n0 = nres;
        send_exp(32'h00000B24, 32'h00800000, 32'h00000B24, 1'b0, 1'b0);
        send_exp(32'h7FFFFFFF, 32'h00800001, 32'h7FFFFFFF, 1'b1, 1'b0);
        idle();
        idle();
        idle();
        chk("post_rst_results", 64'(nres - n0), 64'd2);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
